// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
package ro_meas_pkg;

   // Sequencer states; PICK is a same-cycle decision and has no encoding
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      SETTLE = 3'd2,
      GATE   = 3'd3,
      LATCH  = 3'd4,
      SEND   = 3'd5,
      SHIFT  = 3'd6,
      DONE   = 3'd7
   } state_t;

   // Oscillator indices as seen on counter_select / osc_mask
   localparam int OSC_NAND4     = 0;
   localparam int OSC_NAND4_CAP = 1;
   localparam int OSC_EINV_SUB  = 2;

   // Leading bits of every readout frame
   localparam logic [3:0] FRAME_HEADER = 4'b1010;

   // Readout frame length: header plus counter value
   function automatic int FRAME_LEN(input int counter_length);
      return counter_length + 4;
   endfunction

endpackage

// File: rtl/ro_seq_timer.sv
// Loadable down-counter that times every timed sequencer state.
// It saturates at zero so it can never wrap.
module ro_seq_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value,
   output logic             expired
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] value_reg;

   // Reload on state entry, otherwise count down and hold at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_reg <= '0;
      end else if (load) begin
         value_reg <= load_value;
      end else if (value_reg != '0) begin
         value_reg <= value_reg - ONE;
      end
   end

   assign value   = value_reg;
   assign expired = (value_reg == '0);

endmodule

// File: rtl/ro_measure_sequencer.sv
// Autonomous run controller for the ring-oscillator measurement path:
// clear counters, open the gate window, latch, then read out each enabled
// oscillator through the shared readout shift register.
module ro_measure_sequencer
   import ro_meas_pkg::*;
#(
   parameter int COUNTER_LENGTH = 20,
   parameter int GATE_WIDTH     = 16,
   parameter int SYNC_CYCLES    = 4,
   parameter int SEND_LAT       = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  continuous,
   input  logic                  abort,
   input  logic [GATE_WIDTH-1:0] gate_cycles,
   input  logic [2:0]            osc_mask,
   output logic                  ctr_reset,
   output logic                  latch_counter,
   output logic                  send_counter,
   output logic [1:0]            counter_select,
   output logic                  busy,
   output logic                  frame_active,
   output logic                  done
);

   // Timer width covers the largest gate window and the SHIFT span
   localparam int TW = (GATE_WIDTH > 8) ? GATE_WIDTH : 8;

   // Timer loads are duration-1: a state lasts until the timer reads zero
   localparam logic [TW-1:0]         SYNC_LOAD  = TW'(SYNC_CYCLES - 1);
   localparam logic [TW-1:0]         SHIFT_LOAD = TW'(SEND_LAT + FRAME_LEN(COUNTER_LENGTH) - 1);
   localparam logic [GATE_WIDTH-1:0] GATE_ONE   = GATE_WIDTH'(1);

   state_t                  state_reg, state_next;
   logic [GATE_WIDTH-1:0]   gate_reg, gate_next;
   logic [2:0]              remain_reg, remain_next;
   logic [1:0]              sel_next;
   logic                    tmr_load;
   logic [TW-1:0]           tmr_load_value;
   logic [TW-1:0]           tmr_value_unused;
   logic                    tmr_expired;
   logic [TW-1:0]           gate_load;

   // The count itself is not needed; only expiry drives the FSM
   ro_seq_timer #(.WIDTH(TW)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (tmr_load),
      .load_value (tmr_load_value),
      .value      (tmr_value_unused),
      .expired    (tmr_expired)
   );

   // A gate length of zero is stretched to a single cycle
   assign gate_load = (gate_reg == '0) ? '0 : TW'(gate_reg - GATE_ONE);

   // Next-state, shadow-config and timer-reload decisions (PICK resolved inline)
   always_comb begin
      state_next     = state_reg;
      gate_next      = gate_reg;
      remain_next    = remain_reg;
      sel_next       = counter_select;
      tmr_load       = 1'b0;
      tmr_load_value = SYNC_LOAD;
      if (abort) begin
         state_next = IDLE;
         sel_next   = 2'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  gate_next   = gate_cycles;
                  remain_next = osc_mask;
                  state_next  = CLEAR;
                  tmr_load    = 1'b1;
               end
            end
            CLEAR: begin
               if (tmr_expired) begin
                  state_next = SETTLE;
                  tmr_load   = 1'b1;
               end
            end
            SETTLE: begin
               if (tmr_expired) begin
                  state_next     = GATE;
                  tmr_load       = 1'b1;
                  tmr_load_value = gate_load;
               end
            end
            GATE: begin
               if (tmr_expired) begin
                  state_next = LATCH;
                  tmr_load   = 1'b1;
               end
            end
            LATCH, SHIFT: begin
               if (tmr_expired) begin
                  tmr_load       = 1'b1;
                  tmr_load_value = '0;
                  state_next     = SEND;
                  if (remain_reg[OSC_NAND4]) begin
                     sel_next                 = 2'(OSC_NAND4);
                     remain_next[OSC_NAND4]   = 1'b0;
                  end else if (remain_reg[OSC_NAND4_CAP]) begin
                     sel_next                   = 2'(OSC_NAND4_CAP);
                     remain_next[OSC_NAND4_CAP] = 1'b0;
                  end else if (remain_reg[OSC_EINV_SUB]) begin
                     sel_next                  = 2'(OSC_EINV_SUB);
                     remain_next[OSC_EINV_SUB] = 1'b0;
                  end else begin
                     state_next = DONE;
                  end
               end
            end
            SEND: begin
               state_next     = SHIFT;
               tmr_load       = 1'b1;
               tmr_load_value = SHIFT_LOAD;
            end
            DONE: begin
               if (continuous) begin
                  gate_next   = gate_cycles;
                  remain_next = osc_mask;
                  state_next  = CLEAR;
                  tmr_load    = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // State, shadow config and registered outputs decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         gate_reg       <= '0;
         remain_reg     <= '0;
         counter_select <= 2'd0;
         ctr_reset      <= 1'b0;
         latch_counter  <= 1'b0;
         send_counter   <= 1'b0;
         frame_active   <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         state_reg      <= state_next;
         gate_reg       <= gate_next;
         remain_reg     <= remain_next;
         counter_select <= sel_next;
         ctr_reset      <= (state_next == CLEAR);
         latch_counter  <= (state_next == LATCH);
         send_counter   <= (state_next == SEND);
         frame_active   <= (state_next == SHIFT);
         busy           <= (state_next != IDLE);
         done           <= (state_next == DONE);
      end
   end

endmodule
